// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB bridge: FSM encoding, UART register map
// and control-register field positions.
package uart_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam logic [7:0] UART_TXD    = 8'h00;
    localparam logic [7:0] UART_RXD    = 8'h01;
    localparam logic [7:0] UART_UBRR   = 8'h02;
    localparam logic [7:0] UART_CTRL0  = 8'h03;
    localparam logic [7:0] UART_CTRL1  = 8'h04;
    localparam logic [7:0] UART_STATUS = 8'h05;

    localparam int CTRL0_TXEN      = 8;
    localparam int CTRL0_RXEN      = 9;
    localparam int CTRL0_TXCIE     = 10;
    localparam int CTRL0_RXCIE     = 11;
    localparam int CTRL0_UBRRH_LSB = 12;
    localparam int CTRL0_UBRRH_MSB = 15;

    localparam int CTRL1_DLS_LSB   = 16;
    localparam int CTRL1_DLS_MSB   = 17;
    localparam int CTRL1_STOP      = 18;
    localparam int CTRL1_PEN       = 19;
    localparam int CTRL1_EPS       = 20;

    // True when an address falls inside the UART register window.
    function automatic logic is_uart_reg(input logic [31:0] addr);
        return addr <= 32'(UART_STATUS);
    endfunction

endpackage

// File: rtl/uart_apb_timeout.sv
// Saturating ACCESS-phase cycle counter; 'expired' flags the last permitted
// ACCESS cycle so the FSM can force an error response in that same cycle.
module uart_apb_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pClk,
    input  logic pReset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (W < 1) ? 1 : W;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    // TIMEOUT_CYCLES == 0 disables the timeout entirely.
    assign expired = (TIMEOUT_CYCLES > 0) && enable && (count == LAST);

endmodule

// File: rtl/uart_apb_master.sv
// APB3 initiator bridging a valid/ready command port onto the UART register
// block; one transfer at a time with wait states, slave error and timeout.
//
//   state  | meaning
//   IDLE   | cmd_ready=1, waiting for a command
//   SETUP  | pSel=1, pEnable=0, one cycle
//   ACCESS | pSel=1, pEnable=1, waiting for pReady or timeout
//   RESP   | rsp_valid=1, holding response until rsp_ready
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pClk,
    input  logic              pReset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              pSel,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWdata,
    input  logic [DATA_W-1:0] pReadData,
    input  logic              pReady,
    input  logic              pSlvErr,

    output logic              busy
);

    apb_state_t state;
    logic       accept;
    logic       tmo_expired;

    assign accept = cmd_valid && cmd_ready;

    uart_apb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .pClk    (pClk),
        .pReset  (pReset),
        .clear   (accept),
        .enable  (state == ST_ACCESS),
        .expired (tmo_expired)
    );

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            pSel      <= 1'b0;
            pEnable   <= 1'b0;
            pWrite    <= 1'b0;
            pAddr     <= '0;
            pWdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        pWrite    <= cmd_write;
                        pAddr     <= cmd_addr;
                        pWdata    <= cmd_wdata;
                        pSel      <= 1'b1;
                        pEnable   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    pEnable <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // pReady takes priority over a coincident timeout.
                    if (pReady) begin
                        rsp_rdata <= (pWrite || pSlvErr) ? '0 : pReadData;
                        rsp_err   <= pSlvErr;
                        pSel      <= 1'b0;
                        pEnable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        pSel      <= 1'b0;
                        pEnable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// Randomized scoreboard bench for uart_apb_master with a behavioural APB slave
// and an abstract response model.
module tb_uart_apb_master;
    import uart_apb_pkg::*;

    localparam int TO = 16;

    logic        pClk;
    logic        pReset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        pSel;
    logic        pEnable;
    logic        pWrite;
    logic [31:0] pAddr;
    logic [31:0] pWdata;
    logic [31:0] pReadData;
    logic        pReady;
    logic        pSlvErr;
    logic        busy;

    uart_apb_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pClk(pClk), .pReset(pReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite), .pAddr(pAddr), .pWdata(pWdata),
        .pReadData(pReadData), .pReady(pReady), .pSlvErr(pSlvErr),
        .busy(busy)
    );

    typedef struct {
        int          waits;
        logic        err;
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          access;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int rsp_delay = -1;

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;
    always @(posedge pClk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Response derived from the slave's behaviour and the bridge's rules.
    function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                   input plan_t p);
        exp_t e;
        e.w = w; e.addr = a; e.wdata = d;
        if (TO > 0 && p.waits >= TO) begin
            e.access = TO; e.err = 1'b1; e.rdata = 32'h0;
        end else begin
            e.access = p.waits + 1;
            e.err    = p.err;
            e.rdata  = (w || p.err) ? 32'h0 : p.rdata;
        end
        return e;
    endfunction

    // Behavioural APB slave: pReady after 'waits' stalled ACCESS cycles.
    initial begin
        plan_t cur;
        int    acc_n;
        logic  rdy;
        cur.waits = 0; cur.err = 1'b0; cur.rdata = 32'h0;
        acc_n = 0;
        pReady = 1'b0; pSlvErr = 1'b0; pReadData = 32'h0;
        forever begin
            @(posedge pClk); #1;
            if (!pReset) begin
                acc_n = 0; pReady = 1'b0; pSlvErr = 1'b0;
            end else begin
                if (pSel && !pEnable) begin
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    acc_n = 0;
                end
                if (pSel && pEnable) acc_n++;
                else if (!pSel) acc_n = 0;
                rdy = pSel && pEnable && (acc_n > cur.waits);
                pReady    = rdy;
                pSlvErr   = rdy ? cur.err : 1'b1;
                pReadData = rdy ? cur.rdata : $urandom;
            end
        end
    end

    // Response consumer with forced or random back-pressure.
    initial begin
        bit armed;
        int cnt;
        armed = 0; cnt = 0; rsp_ready = 1'b0;
        forever begin
            @(posedge pClk); #1;
            if (rsp_valid) begin
                if (!armed) begin
                    cnt   = (rsp_delay >= 0) ? rsp_delay : int'($urandom_range(0, 2));
                    armed = 1;
                end
                rsp_ready = (cnt == 0);
                if (cnt > 0) cnt--;
            end else begin
                rsp_ready = 1'b0;
                armed     = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        int   acc_c, ns, na;
        bit   in_resp;
        acc_c = 0; ns = 0; na = 0; in_resp = 0;
        forever begin
            @(negedge pClk);
            if (!pReset) begin
                in_resp = 0;
                continue;
            end
            if (cmd_valid && cmd_ready) begin
                acc_c = cyc; ns = 0; na = 0;
                chk("accept_psel_low", pSel, 0);
                chk("accept_not_busy", busy, 0);
            end
            if (pSel) begin
                if (exp_q.size() == 0) chk("unexpected_psel", 1, 0);
                else begin
                    e = exp_q[0];
                    if (pEnable) na++; else ns++;
                    chk("paddr", pAddr, e.addr);
                    chk("pwrite", pWrite, e.w);
                    if (e.w) chk("pwdata", pWdata, e.wdata);
                    chk("busy_active", busy, 1);
                    chk("cmd_ready_active", cmd_ready, 0);
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e = exp_q[0];
                    if (!in_resp) begin
                        in_resp = 1;
                        chk("latency", cyc - acc_c, 2 + e.access);
                        chk("setup_cycles", ns, 1);
                        chk("access_cycles", na, e.access);
                    end
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    chk("resp_psel", pSel, 0);
                    chk("resp_penable", pEnable, 0);
                    chk("resp_cmd_ready", cmd_ready, 0);
                    chk("resp_paddr_hold", pAddr, e.addr);
                    if (rsp_ready) begin
                        e = exp_q.pop_front();
                        in_resp = 0;
                    end
                end
            end
        end
    end

    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int waits, input logic err, input logic [31:0] rd);
        plan_t p;
        bit    ok;
        p.waits = waits; p.err = err; p.rdata = rd;
        plan_q.push_back(p);
        exp_q.push_back(model(w, a, d, p));
        @(posedge pClk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge pClk);
            if (cmd_ready) begin ok = 1; break; end
        end
        chk("cmd_accepted", ok, 1);
        @(posedge pClk); #1;
        cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1);
        cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge pClk);
            if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
        end
        chk("drain", ok, 1);
    endtask

    initial begin
        logic [31:0] ctrl0_val;
        int          seen;
        bit          w;
        int          r, waits;
        logic [31:0] a;

        pReset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0;
        repeat (3) @(posedge pClk);
        @(negedge pClk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_psel", pSel, 0);
        chk("rst_penable", pEnable, 0);
        chk("rst_pwrite", pWrite, 0);
        chk("rst_paddr", pAddr, 0);
        chk("rst_pwdata", pWdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        #2 pReset = 1'b1;
        repeat (2) @(negedge pClk);
        chk("idle_cmd_ready", cmd_ready, 1);

        do_cmd(1'b1, 32'(UART_TXD), 32'h41, 0, 1'b0, 32'hDEAD_BEEF);
        do_cmd(1'b0, 32'(UART_RXD), 32'h0, 3, 1'b0, 32'h5A);
        do_cmd(1'b0, 32'(UART_RXD), 32'h0, 1000, 1'b0, 32'h77);
        do_cmd(1'b0, 32'(UART_UBRR), 32'h0, TO - 1, 1'b0, 32'h1234);
        do_cmd(1'b0, 32'(UART_UBRR), 32'h0, TO, 1'b0, 32'h1234);
        do_cmd(1'b0, 32'(UART_STATUS), 32'h0, 0, 1'b1, 32'hA5A5);
        do_cmd(1'b0, 32'(UART_STATUS), 32'h0, 2, 1'b0, 32'h0C);
        drain();

        rsp_delay = 5;
        do_cmd(1'b1, 32'(UART_CTRL1), 32'h1 << CTRL1_PEN, 0, 1'b0, 32'h0);
        do_cmd(1'b0, 32'(UART_CTRL1), 32'h0, 1, 1'b0, 32'h0008_0000);
        rsp_delay = -1;
        drain();

        do_cmd(1'b0, 32'(UART_RXD), 32'h0, 5, 1'b0, 32'h99);
        seen = 0;
        for (int i = 0; i < 50 && seen < 2; i++) begin
            @(negedge pClk);
            if (pSel && pEnable) seen++;
        end
        chk("reached_access2", seen, 2);
        #2 pReset = 1'b0;
        #1;
        chk("midrst_psel", pSel, 0);
        chk("midrst_penable", pEnable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        plan_q.delete();
        @(negedge pClk);
        #2 pReset = 1'b1;
        repeat (2) @(negedge pClk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        ctrl0_val = (32'h1 << CTRL0_TXEN) | (32'h1 << CTRL0_RXEN) | (32'h6 << CTRL0_UBRRH_LSB);
        do_cmd(1'b1, 32'(UART_CTRL0), ctrl0_val, 1, 1'b0, 32'h0);
        drain();

        for (int t = 0; t < 40; t++) begin
            w = 1'(($urandom_range(0, 1)));
            a = 32'($urandom_range(0, 5));
            r = int'($urandom_range(0, 9));
            if (r < 6)      waits = int'($urandom_range(0, 3));
            else if (r < 8) waits = int'($urandom_range(TO - 2, TO + 1));
            else            waits = int'($urandom_range(0, 8));
            do_cmd(w, a, $urandom, waits, ($urandom_range(0, 4) == 0), $urandom);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
